noc_mem_endpoint: RTL
=====================

# noc_mem_endpoint

Leaf responder at a NOC output port: accepts `{addr,data}` write packets from a switch output using the enq/full flow-control convention, buffers them in a receive FIFO, and commits them into a local single-port memory bank through a two-stage drain pipeline. A local read port gives cores and the testbench access to the bank, with priority over writes. Packet and error counters support traffic accounting.

## Interface
- ADDR_WIDTH, 16, packet address field width (packet bits [ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH]).
- DATA_WIDTH, 32, packet data field width (packet bits [DATA_WIDTH-1:0]).
- DEPTH, 4, receive FIFO entries; power of two, ≥2.
- MEM_WORDS, 16, memory words; power of two; index = addr[$clog2(MEM_WORDS)-1:0].
- ID_WIDTH, 3, routing field width = addr[ADDR_WIDTH-1 -: ID_WIDTH].
- ENDPOINT_ID, 0, expected routing field value for this endpoint.
---
- clk  in  1  clock.
- rst_l  in  1  reset; asynchronous, active-low.
- enq_i  in  1  upstream enqueue strobe; legal only while full_o=0.
- pkt_i  in  ADDR_WIDTH+DATA_WIDTH  packet {addr,data}.
- full_o  out  1  receive FIFO full.
- rd_en_i  in  1  local read request.
- rd_addr_i  in  $clog2(MEM_WORDS)  local read word index.
- rd_data_o  out  DATA_WIDTH  registered read data.
- rd_valid_o  out  1  rd_data_o valid this cycle.
- pkt_count_o  out  16  packets committed to memory.
- err_count_o  out  16  packets dropped for a routing mismatch.
- busy_o  out  1  FIFO non-empty or stage register valid.

## Operation
- Receive FIFO: circular buffer with occupancy counter 0..DEPTH. full_o = (count==DEPTH), decoded from registered state only, with no combinational path from enq_i. Upstream samples full_o in the same cycle it drives enq_i.
- enq_i while full_o=1 is a protocol error. The packet is discarded and state is unchanged. Simulation raises $error.
- Stage register S (packet and valid bit). Pop the FIFO into S when the FIFO is non-empty and either S is empty or S commits this cycle. A simultaneous enq and pop leaves count unchanged.
- Commit: when S is valid and rd_en_i=0, write S.data to mem[S.addr index], clear or refill S, and increment pkt_count_o.
- When S is valid and rd_en_i=1, the read wins. S stalls and the FIFO keeps accepting until full.
- Read: rd_en_i at cycle t gives rd_data_o=mem[rd_addr_i] and rd_valid_o=1 in cycle t+1. rd_data_o holds its value when there is no read.
- A read and a stalled write to the same index in the same cycle return the old value.
- Counters saturate at 16'hFFFF.
- Reset values: full_o=0, rd_data_o=0, rd_valid_o=0, pkt_count_o=0, err_count_o=0, busy_o=0. FIFO pointers, count, and S.valid are cleared. Memory contents are not reset.
- Reset mid-operation discards all buffered and in-flight packets. Memory writes already committed persist.

## Timing
- enq_i sampled at edge E0 → packet popped into S at E1 → memory written at E2. This gives a minimum 2-cycle write latency, plus one cycle per stalling read.
- Sustained throughput is 1 packet/cycle with no reads. full_o never asserts under sustained traffic without reads.
- full_o rises the cycle after the enq that fills the FIFO, when no pop occurs on that edge. It falls the cycle after the first pop.
- busy_o is combinational from registered state.

## Configuration
- NOC_EP_STRICT_EN defined:
  - At commit time, a packet whose routing field ≠ ENDPOINT_ID is dropped. There is no memory write and no pkt_count_o increment.
  - err_count_o increments, saturating.
  - Drop occupies the commit slot identically, with the same read-priority stall.
- NOC_EP_STRICT_EN undefined:
  - The routing field is ignored and every packet is written.
  - err_count_o is tied to 0.

## Test plan
- Single write then read: enq {addr=16'h0005,data=32'hDEADBEEF} → write at E2; rd_en_i idx 5 issued afterward → rd_data_o=32'hDEADBEEF, rd_valid_o=1 one cycle later; pkt_count_o=1.
- Backpressure: rd_en_i held high, 5 back-to-back enqs with DEPTH=4 → S holds packet 1, FIFO holds packets 2–5. full_o=1 after the 5th enq. After releasing rd_en_i, all 5 commit on consecutive cycles and pkt_count_o=5.
- Read/write collision: S holds data 32'h1 for index 3, mem[3]=32'h0, rd_en_i idx 3 → returns 32'h0; next cycle the write commits and a subsequent read returns 32'h1.
- Wrap-around: 12 sequential packets to indices 0..11 with interleaved reads → all read back correctly; FIFO pointers wrap three times.
- Strict mode (NOC_EP_STRICT_EN, ENDPOINT_ID=0): addr=16'hE002 (routing=7) → mem[2] unchanged, err_count_o=1, pkt_count_o=0.
- Reset mid-traffic: assert rst_l low with 3 packets buffered → all outputs return to reset values immediately; after release, a fresh packet commits with 2-cycle latency.

Source files
------------

// File: rtl/noc_mem_endpoint_if.sv
// Switch-facing enq/full packet port and local read port of noc_mem_endpoint.
interface noc_mem_endpoint_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 16
);
   logic                             enq_i;
   logic [ADDR_WIDTH+DATA_WIDTH-1:0] pkt_i;
   logic                             full_o;
   logic                             rd_en_i;
   logic [$clog2(MEM_WORDS)-1:0]     rd_addr_i;
   logic [DATA_WIDTH-1:0]            rd_data_o;
   logic                             rd_valid_o;

   modport master (output enq_i, pkt_i, rd_en_i, rd_addr_i,
                   input  full_o, rd_data_o, rd_valid_o);
   modport slave  (input  enq_i, pkt_i, rd_en_i, rd_addr_i,
                   output full_o, rd_data_o, rd_valid_o);
endinterface

// File: rtl/noc_mem_endpoint.sv
// NOC leaf responder: receive FIFO -> stage register -> single-port memory, read port wins.
// Optional routing check at commit enabled by defining NOC_EP_STRICT_EN.
module noc_mem_endpoint #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 4,
   parameter int MEM_WORDS   = 16,
   parameter int ID_WIDTH    = 3,
   parameter int ENDPOINT_ID = 0
) (
   input  logic               clk,
   input  logic               rst_l,
   noc_mem_endpoint_if.slave  bus,
   output logic [15:0]        pkt_count_o,
   output logic [15:0]        err_count_o,
   output logic               busy_o
);
   localparam int PKT_W = ADDR_WIDTH + DATA_WIDTH;
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0]    FULL_CNT = CNT_W'(DEPTH);
   localparam logic [ID_WIDTH-1:0] EP_ID    = ID_WIDTH'(ENDPOINT_ID);

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [PKT_W-1:0]      fifo_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_q  [MEM_WORDS];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PKT_W-1:0]      s_pkt_q;
   logic                  s_vld_q, s_vld_d;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q;
   logic [15:0]           pkt_cnt_q, pkt_cnt_d;

   logic                  full, empty, push, pop, commit, route_ok, route_match, mem_we;
   logic [ADDR_WIDTH-1:0] s_addr;
   logic [DATA_WIDTH-1:0] s_data;
   logic [IDX_W-1:0]      s_idx;
   logic                  unused_ok;

   assign s_addr      = s_pkt_q[PKT_W-1:DATA_WIDTH];
   assign s_data      = s_pkt_q[DATA_WIDTH-1:0];
   assign s_idx       = s_addr[IDX_W-1:0];
   assign route_match = (s_addr[ADDR_WIDTH-1 -: ID_WIDTH] == EP_ID);
   assign unused_ok   = ^{s_addr, route_match};

   // full_o comes from the registered count only, never from enq_i
   assign full   = (count_q == FULL_CNT);
   assign empty  = (count_q == '0);
   assign push   = bus.enq_i && !full;
   assign commit = s_vld_q && !bus.rd_en_i;
   assign pop    = !empty && (!s_vld_q || commit);
   assign mem_we = commit && route_ok;

`ifdef NOC_EP_STRICT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   assign route_ok = route_match;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (commit && !route_ok) err_cnt_d = sat_inc(err_cnt_q);
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) err_cnt_q <= '0;
      else        err_cnt_q <= err_cnt_d;
   end

   assign err_count_o = err_cnt_q;
`else
   assign route_ok    = 1'b1;
   assign err_count_o = '0;
`endif

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      s_vld_d   = s_vld_q;
      pkt_cnt_d = pkt_cnt_q;
      rd_data_d = rd_data_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      if (pop)         s_vld_d = 1'b1;
      else if (commit) s_vld_d = 1'b0;
      if (mem_we) pkt_cnt_d = sat_inc(pkt_cnt_q);
      // mem_q is sampled before this edge's commit, so a colliding read sees the old word
      if (bus.rd_en_i) rd_data_d = mem_q[bus.rd_addr_i];
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         s_vld_q    <= 1'b0;
         pkt_cnt_q  <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         s_vld_q    <= s_vld_d;
         pkt_cnt_q  <= pkt_cnt_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= bus.rd_en_i;
      end
   end

   // Storage: FIFO slots, stage payload and memory bank carry no reset
   always_ff @(posedge clk) begin
      if (push)   fifo_q[wr_ptr_q] <= bus.pkt_i;
      if (pop)    s_pkt_q          <= fifo_q[rd_ptr_q];
      if (mem_we) mem_q[s_idx]     <= s_data;
   end

   enq_while_full_a: assert property (@(posedge clk) disable iff (!rst_l) !(bus.enq_i && full))
      else $error("noc_mem_endpoint: enq_i asserted while full_o=1, packet dropped");

   assign bus.full_o     = full;
   assign bus.rd_data_o  = rd_data_q;
   assign bus.rd_valid_o = rd_valid_q;
   assign pkt_count_o    = pkt_cnt_q;
   assign busy_o         = !empty || s_vld_q;
endmodule
